// File: rtl/ka_pkg.sv
// ka_pkg: default field constants, FSM state encoding and a reference carry-less multiply
package ka_pkg;
  localparam int M_B283 = 283;
  localparam int K1_B283 = 12;
  localparam int K2_B283 = 7;
  localparam int K3_B283 = 5;
  localparam int M_B163 = 163;
  localparam int K1_B163 = 7;
  localparam int K2_B163 = 6;
  localparam int K3_B163 = 3;
  localparam int CLMUL_W = 512;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_P_LO  = 3'd1,
    S_P_HI  = 3'd2,
    S_P_MID = 3'd3,
    S_COMB  = 3'd4,
    S_RED   = 3'd5,
    S_DONE  = 3'd6
  } state_t;
  function automatic logic [2*CLMUL_W-2:0] clmul_ref(input logic [CLMUL_W-1:0] a, input logic [CLMUL_W-1:0] b);
    logic [2*CLMUL_W-2:0] p;
    p = '0;
    for (int i = 0; i < CLMUL_W; i++) if (b[i]) p = p ^ ((2*CLMUL_W-1)'(a) << i);
    return p;
  endfunction
endpackage

// File: rtl/ka_gf2m_mul_seq_if.sv
// ka_gf2m_mul_seq_if: operand/result handshake bus; slave = multiplier (in_valid/a/b/out_ready in; in_ready/out_valid/y/busy out)
interface ka_gf2m_mul_seq_if
  import ka_pkg::*;
#(
  parameter int M = M_B283
);
  logic in_valid;
  logic in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [2*M-2:0] y;
  logic busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, y, busy);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, y, busy);
endinterface

// File: rtl/ka_comb_mul.sv
// ka_comb_mul: combinational recursive Karatsuba carry-less multiply, ports a[W], b[W] in, p[2W-1] out
module ka_comb_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-2:0] p
);
  if (W <= 8) begin : g_base
    always_comb begin
      p = '0;
      for (int i = 0; i < W; i++) p = p ^ ((2*W-1)'(a & {W{b[i]}}) << i);
    end
  end else begin : g_rec
    localparam int H = (W + 1) / 2;
    logic [H-1:0] al, ah, bl, bh, am, bm;
    logic [2*H-2:0] pl, ph, pm;
    assign al = a[H-1:0];
    assign ah = H'(a[W-1:H]);
    assign bl = b[H-1:0];
    assign bh = H'(b[W-1:H]);
    assign am = al ^ ah;
    assign bm = bl ^ bh;
    ka_comb_mul #(.W(H)) u_lo (.a(al), .b(bl), .p(pl));
    ka_comb_mul #(.W(H)) u_hi (.a(ah), .b(bh), .p(ph));
    ka_comb_mul #(.W(H)) u_mid (.a(am), .b(bm), .p(pm));
    assign p = (2*W-1)'(pl) ^ ((2*W-1)'(pl ^ ph ^ pm) << H) ^ ((2*W-1)'(ph) << (2*H));
  end
endmodule

// File: rtl/ka_gf2m_mul_seq.sv
// ka_gf2m_mul_seq: multi-cycle Karatsuba GF(2)[x] multiplier with optional pentanomial reduction; ports clk, rst_n (sync, active low), io (slave handshake bus)
module ka_gf2m_mul_seq
  import ka_pkg::*;
#(
  parameter int M = M_B283,
  parameter int REDUCE = 1,
  parameter int K1 = K1_B283,
  parameter int K2 = K2_B283,
  parameter int K3 = K3_B283
) (
  input logic clk,
  input logic rst_n,
  ka_gf2m_mul_seq_if.slave io
);
  localparam int H = (M + 1) / 2;
  localparam int PW = 2 * H - 1;
  localparam int YW = 2 * M - 1;
  localparam int RW = M + K1;
  if (M < 4 || K1 > M / 2 - 1 || K2 >= K1 || K3 >= K2 || K3 < 1) begin : g_bad_params
    $error("ka_gf2m_mul_seq: illegal M/K1/K2/K3");
  end
  function automatic logic [RW-1:0] fold(input logic [RW-1:0] lo, input logic [RW-1:0] t);
    return lo ^ t ^ (t << K1) ^ (t << K2) ^ (t << K3);
  endfunction
  function automatic logic [M-1:0] reduce_mod(input logic [YW-1:0] r);
    logic [RW-1:0] r1;
    r1 = fold(RW'(r[M-1:0]), RW'(r[YW-1:M]));
    return M'(fold(RW'(r1[M-1:0]), RW'(r1[RW-1:M])));
  endfunction
  state_t state_q, state_d;
  logic [M-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0] p_lo_q, p_lo_d, p_hi_q, p_hi_d, p_mid_q, p_mid_d, prod;
  logic [YW-1:0] y_q, y_d;
  logic [H-1:0] a_lo, a_hi, b_lo, b_hi, op_a, op_b;
  logic accept;
  assign a_lo = a_q[H-1:0];
  assign a_hi = H'(a_q[M-1:H]);
  assign b_lo = b_q[H-1:0];
  assign b_hi = H'(b_q[M-1:H]);
  assign op_a = state_q == S_P_LO ? a_lo : state_q == S_P_HI ? a_hi : a_lo ^ a_hi;
  assign op_b = state_q == S_P_LO ? b_lo : state_q == S_P_HI ? b_hi : b_lo ^ b_hi;
  ka_comb_mul #(.W(H)) u_mul (.a(op_a), .b(op_b), .p(prod));
  assign io.in_ready = state_q == S_IDLE || (state_q == S_DONE && io.out_ready);
  assign io.out_valid = state_q == S_DONE;
  assign io.busy = state_q != S_IDLE;
  assign io.y = y_q;
  assign accept = io.in_valid && io.in_ready;
  always_comb begin
    state_d = state_q;
    a_d = accept ? io.a : a_q;
    b_d = accept ? io.b : b_q;
    p_lo_d = state_q == S_P_LO ? prod : p_lo_q;
    p_hi_d = state_q == S_P_HI ? prod : p_hi_q;
    p_mid_d = state_q == S_P_MID ? prod : p_mid_q;
    y_d = y_q;
    case (state_q)
      S_IDLE: state_d = accept ? S_P_LO : S_IDLE;
      S_P_LO: state_d = S_P_HI;
      S_P_HI: state_d = S_P_MID;
      S_P_MID: state_d = S_COMB;
      S_COMB: begin
        y_d = YW'(p_lo_q) ^ (YW'(p_lo_q ^ p_hi_q ^ p_mid_q) << H) ^ (YW'(p_hi_q) << (2 * H));
        state_d = REDUCE != 0 ? S_RED : S_DONE;
      end
      S_RED: begin
        y_d = YW'(reduce_mod(y_q));
        state_d = S_DONE;
      end
      S_DONE: state_d = accept ? S_P_LO : io.out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      p_lo_q <= '0;
      p_hi_q <= '0;
      p_mid_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      p_lo_q <= p_lo_d;
      p_hi_q <= p_hi_d;
      p_mid_q <= p_mid_d;
      y_q <= y_d;
    end
  end
endmodule

// File: tb/tb_ka_gf2m_mul_seq.sv
// tb_ka_gf2m_mul_seq: directed and randomized checks of ka_gf2m_mul_seq against a long-division reference model
module tb_ka_gf2m_mul_seq;
  import ka_pkg::*;
  localparam int M = M_B283;
  localparam int MW = 576;
  logic clk = 1'b0;
  logic rst_n_d;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  ka_gf2m_mul_seq_if #(.M(M)) bus0 ();
  ka_gf2m_mul_seq_if #(.M(M)) bus1 ();
  ka_gf2m_mul_seq #(.M(M), .REDUCE(1), .K1(K1_B283), .K2(K2_B283), .K3(K3_B283)) dut_red (.clk(clk), .rst_n(rst_n_d), .io(bus0));
  ka_gf2m_mul_seq #(.M(M), .REDUCE(0), .K1(K1_B283), .K2(K2_B283), .K3(K3_B283)) dut_raw (.clk(clk), .rst_n(rst_n_d), .io(bus1));
  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [MW-1:0] rnd_vec(input int m);
    logic [MW-1:0] v;
    v = '0;
    for (int i = 0; i < m; i++) v[i] = 1'($urandom);
    return v;
  endfunction
  function automatic logic [MW-1:0] ref_y(input logic [CLMUL_W-1:0] a, input logic [CLMUL_W-1:0] b,
                                          input int m, input int red, input int k1, input int k2, input int k3);
    logic [2*CLMUL_W-2:0] p;
    p = clmul_ref(a, b);
    if (red != 0)
      for (int i = 2 * m - 2; i >= m; i--)
        if (p[i]) begin
          p[i] = 1'b0;
          p[i-m+k1] = ~p[i-m+k1];
          p[i-m+k2] = ~p[i-m+k2];
          p[i-m+k3] = ~p[i-m+k3];
          p[i-m] = ~p[i-m];
        end
    return p[MW-1:0];
  endfunction
  task automatic wait0(input bit junk, output int lat);
    lat = 0;
    while (!bus0.out_valid && lat < 20) begin
      check("busy_in_ready", bus0.in_ready, 0);
      check("busy_flag", bus0.busy, 1);
      if (junk) begin
        bus0.in_valid = 1'b1;
        bus0.a = M'(rnd_vec(M));
        bus0.b = M'(rnd_vec(M));
      end
      @(posedge clk); #1;
      lat++;
    end
    bus0.in_valid = 1'b0;
  endtask
  task automatic op0(input logic [M-1:0] a, input logic [M-1:0] b, input bit junk, output int lat);
    check("idle_in_ready", bus0.in_ready, 1);
    bus0.a = a;
    bus0.b = b;
    bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    wait0(junk, lat);
  endtask
  task automatic pop0();
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    check("pop_out_valid", bus0.out_valid, 0);
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int MM = g == 0 ? 9 : M_B163;
    localparam int T1 = g == 0 ? 3 : K1_B163;
    localparam int T2 = g == 0 ? 2 : K2_B163;
    localparam int T3 = g == 0 ? 1 : K3_B163;
    localparam int N = g == 0 ? 4000 : 2000;
    logic rst_n;
    logic done = 1'b0;
    ka_gf2m_mul_seq_if #(.M(MM)) bus ();
    ka_gf2m_mul_seq #(.M(MM), .REDUCE(1), .K1(T1), .K2(T2), .K3(T3)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
    initial begin
      logic [MW-1:0] q[$];
      int sent, got, cyc;
      bit held;
      sent = 0;
      got = 0;
      cyc = 0;
      held = 1'b0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      while (got < N && cyc < 20 * N) begin
        bus.in_valid = (sent < N) && ($urandom_range(7, 0) != 0);
        bus.a = MM'(rnd_vec(MM));
        bus.b = MM'(rnd_vec(MM));
        case ($urandom_range(15, 0))
          0: bus.a = '0;
          1: bus.a = MM'(1);
          2: bus.b = {MM{1'b1}};
          default: ;
        endcase
        bus.out_ready = $urandom_range(3, 0) != 0;
        #1;
        if (held) check($sformatf("m%0d_hold_valid", MM), bus.out_valid, 1);
        if (bus.out_valid) begin
          check($sformatf("m%0d_q_nonempty", MM), q.size() != 0, 1);
          if (q.size() != 0) begin
            check($sformatf("m%0d_y", MM), bus.y, q[0]);
            if (bus.out_ready) begin
              void'(q.pop_front());
              got++;
            end
          end
        end
        held = bus.out_valid && !bus.out_ready;
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(ref_y(CLMUL_W'(bus.a), CLMUL_W'(bus.b), MM, 1, T1, T2, T3));
          sent++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("m%0d_count", MM), got, N);
      check($sformatf("m%0d_left", MM), q.size(), 0);
      done = 1'b1;
    end
  end
  initial begin
    int lat;
    logic [M-1:0] ra, rb, one;
    logic [MW-1:0] exp_y;
    one = M'(1);
    rst_n_d = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b0;
    bus0.a = '0;
    bus0.b = '0;
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_y", bus0.y, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_in_ready", bus0.in_ready, 1);
    rst_n_d = 1'b1;
    op0(one, M'(2), 1'b0, lat);
    check("t1_lat", lat, 5);
    check("t1_y", bus0.y, 2);
    pop0();
    op0(one << 282, M'(2), 1'b0, lat);
    check("t2_y", bus0.y, 'h10a1);
    pop0();
    for (int i = 0; i < 8; i++) begin
      ra = i == 0 ? '0 : i == 1 ? one : i == 2 ? {M{1'b1}} : M'(rnd_vec(M));
      rb = i == 3 ? one : M'(rnd_vec(M));
      op0(ra, rb, i[0], lat);
      check("r283_lat", lat, 5);
      check("r283_y", bus0.y, ref_y(CLMUL_W'(ra), CLMUL_W'(rb), M, 1, K1_B283, K2_B283, K3_B283));
      pop0();
    end
    bus1.a = one << 282;
    bus1.b = one << 282;
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_y = '0;
    exp_y[564] = 1'b1;
    check("t3_lat", lat, 4);
    check("t3_y", bus1.y, exp_y);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check("t3_pop", bus1.out_valid, 0);
    ra = M'(rnd_vec(M));
    rb = M'(rnd_vec(M));
    op0(ra, rb, 1'b0, lat);
    exp_y = ref_y(CLMUL_W'(ra), CLMUL_W'(rb), M, 1, K1_B283, K2_B283, K3_B283);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", bus0.out_valid, 1);
      check("bp_y", bus0.y, exp_y);
    end
    ra = M'(rnd_vec(M));
    rb = M'(rnd_vec(M));
    bus0.a = ra;
    bus0.b = rb;
    bus0.in_valid = 1'b1;
    bus0.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", bus0.in_ready, 1);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b0;
    wait0(1'b0, lat);
    check("b2b_lat", lat, 5);
    check("b2b_y", bus0.y, ref_y(CLMUL_W'(ra), CLMUL_W'(rb), M, 1, K1_B283, K2_B283, K3_B283));
    pop0();
    bus0.a = M'(rnd_vec(M));
    bus0.b = M'(rnd_vec(M));
    bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", bus0.busy, 1);
    rst_n_d = 1'b0;
    @(posedge clk); #1;
    rst_n_d = 1'b1;
    check("mid_rst_out_valid", bus0.out_valid, 0);
    check("mid_rst_y", bus0.y, 0);
    check("mid_rst_in_ready", bus0.in_ready, 1);
    check("mid_rst_busy", bus0.busy, 0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_out", bus0.out_valid, 0);
    op0(M'(3), M'(3), 1'b0, lat);
    check("t5_lat", lat, 5);
    check("t5_y", bus0.y, 5);
    pop0();
    lat = 0;
    while (!(g_rnd[0].done && g_rnd[1].done) && lat < 200000) begin
      @(posedge clk);
      lat++;
    end
    check("rnd_done", {g_rnd[1].done, g_rnd[0].done}, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
